tri_bus_arbiter: RTL

- Round-robin arbiter and sequencer for the shared tri-state data bus inside the MMU datapath.
- Takes bus requests from NUM_REQ drivers and grants exactly one owner at a time, for bursts of up to MAX_BURST beats.
- Drives the per-driver buffer enables (con) and the capture-register load enable (cap_en).
- Optionally inserts a one-cycle all-released turnaround between owners so two drivers never overlap on the bus.

---
 rtl/tri_bus_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - round-robin owner arbiter for the shared tri-state data bus
//
// Grants the shared bus to one of NUM_REQ drivers at a time, for bursts of up
// to MAX_BURST beats, and optionally inserts a one-cycle all-released
// turnaround between owners so two drivers never overlap on the bus.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req       per-driver level request, held high while the driver has data
//   gnt       registered one-hot grant
//   con       tri-state buffer enables, identical to gnt
//   cap_en    capture-register load enable (a beat: owner still requesting)
//   owner_id  binary index of the current owner, 0 when there is none
//   busy      high while granting or in turnaround
module tri_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1,
  parameter int ID_W       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [NUM_REQ-1:0]  con,
  output logic                cap_en,
  output logic [ID_W-1:0]     owner_id,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [NUM_REQ-1:0]  gnt_d;
  logic [ID_W-1:0]     owner_d;
  logic [ID_W-1:0]     ptr, ptr_d;
  logic [7:0]          beat_cnt, beat_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 win_valid;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W-1:0]      win_next;
  logic                 own_req;
  logic                 release_now;

  // Rotate req so bit 0 is the requester at ptr; the lowest set bit of the
  // rotated vector is then the round-robin winner.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    int sum;
    int nxt;
    win_valid = 1'b0;
    win_idx   = '0;
    win_next  = '0;
    sum       = 0;
    nxt       = 0;
    // Descending scan so the lowest offset is the last (winning) assignment.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_valid = 1'b1;
        sum       = int'(ptr) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        win_idx   = ID_W'(sum);
      end
    end
    nxt = int'(win_idx) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    win_next = ID_W'(nxt);
  end

  // gnt is zero outside GRANT, so masking req with it gives the owner's request.
  assign own_req     = |(req & gnt);
  assign release_now = !own_req || (beat_cnt == 8'(MAX_BURST - 1));

  // State register, together with the registered grant bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      owner_id <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      owner_id <= owner_d;
      ptr      <= ptr_d;
      beat_cnt <= beat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    owner_d = owner_id;
    ptr_d   = ptr;
    beat_d  = beat_cnt;
    case (state)
      ST_GRANT: begin
        if (own_req) beat_d = beat_cnt + 8'd1;
        if (release_now) begin
          beat_d = '0;
          if (TURNAROUND != 0 || !win_valid) begin
            state_d = (TURNAROUND != 0) ? ST_TURN : ST_IDLE;
            gnt_d   = '0;
            owner_d = '0;
          end else begin
            // Direct handoff: the buffer enables switch on a single edge.
            state_d = ST_GRANT;
            gnt_d   = NUM_REQ'(1) << win_idx;
            owner_d = win_idx;
            ptr_d   = win_next;
          end
        end
      end
      default: begin
        // IDLE and TURN both arbitrate; TURN never lasts past one cycle.
        beat_d = '0;
        if (win_valid) begin
          state_d = ST_GRANT;
          gnt_d   = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          ptr_d   = win_next;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          owner_d = '0;
        end
      end
    endcase
  end

  // Output logic; cap_en is combinational from req so the capture register
  // loads on the same edge the owner presents its beat.
  always_comb begin
    con    = gnt;
    cap_en = (state == ST_GRANT) && own_req;
    busy   = (state != ST_IDLE);
  end

endmodule
